// File: rtl/transmitter_pkg.sv
// Definitions shared by the transmitter and receiver: handshake state encodings and
// default data-path dimensions.
package transmitter_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_e;

endpackage

// File: rtl/hs_fifo.sv
// Word buffer for the transmitter: storage array, wrapping read/write pointers and
// an occupancy counter. The head word is read combinationally from the array.
module hs_fifo
   import transmitter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [CW-1:0]    count_o,
   output logic [CW-1:0]    count_d_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;

   // NOTE: every variable assigned here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      unique case ({wr_en_i, rd_en_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: ;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // NOTE: the storage array carries no reset; its contents are only observed
   // behind a nonzero count, so a reset would only cost flops.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign count_d_o = count_d;

endmodule

// File: rtl/transmitter.sv
// Valid/ready transmitter: buffers upstream words in hs_fifo and presents them
// downstream in load order, with a registered load_ready.
module transmitter
   import transmitter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic [CW-1:0]    count
);

   tx_state_e     state_q, state_d;
   logic          load_ready_q;
   logic          wr_en, rd_en;
   logic [CW-1:0] count_d;

   assign wr_en = load_valid && load_ready_q;
   assign rd_en = valid && ready;

   hs_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (load_data),
      .rd_en_i   (rd_en),
      .rd_data_o (data),
      .count_o   (count),
      .count_d_o (count_d)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (wr_en) state_d = SEND;
         SEND: if (rd_en && !wr_en && count == CW'(1)) state_d = IDLE;
      endcase
   end

   // load_ready looks at next-state occupancy so a full buffer that drains on this
   // edge reopens one cycle later, never combinationally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         load_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_ready_q <= (count_d < CW'(DEPTH));
      end
   end

   assign valid      = (state_q == SEND);
   assign load_ready = load_ready_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed and randomized checks of the transmitter handshake, ordering, full and
// reset behaviour against hand-computed values and a reference queue.
module tb_transmitter;
   import transmitter_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic [CW-1:0]    count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [WIDTH-1:0] model[$];
   logic             hold_pending;
   logic [WIDTH-1:0] hold_data;

   transmitter #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .valid      (valid),
      .ready      (ready),
      .data       (data),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Advance one rising edge; outputs are then sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One randomized-phase cycle: scoreboard and hold-rule checks around the edge.
   task automatic cycle();
      logic xfer, ld;
      if (hold_pending) begin
         check("hold_valid", valid, 1);
         check("hold_data", data, hold_data);
      end
      xfer = valid && ready;
      ld   = load_valid && load_ready;
      if (xfer) begin
         check("xfer_nonempty", model.size() != 0, 1);
         if (model.size() != 0) begin
            check("order", data, model[0]);
            void'(model.pop_front());
         end
      end
      if (ld) model.push_back(load_data);
      hold_pending = valid && !ready;
      hold_data    = data;
      step();
      check("rand_count", count, model.size());
      check("rand_valid", valid, model.size() != 0);
      check("rand_load_ready", load_ready, model.size() < DEPTH);
   endtask

   initial begin
      rst = 1'b0; load_valid = 1'b0; load_data = '0; ready = 1'b0;
      step();
      step();
      check("rst_valid", valid, 0);
      check("rst_count", count, 0);
      check("rst_load_ready", load_ready, 0);
      rst = 1'b1;
      step();
      check("rst_release_load_ready", load_ready, 1);

      // Single word held under back-pressure, then transferred.
      load_valid = 1'b1; load_data = 8'hA5;
      step();
      load_valid = 1'b0;
      check("a5_valid", valid, 1);
      check("a5_count", count, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("a5_hold_valid", valid, 1);
         check("a5_hold_data", data, 8'hA5);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("a5_done_valid", valid, 0);
      check("a5_done_count", count, 0);

      // Fill to full, offer an extra word, then drain back-to-back.
      for (int i = 1; i <= 4; i++) begin
         load_valid = 1'b1; load_data = WIDTH'(i);
         step();
      end
      check("full_count", count, 4);
      check("full_load_ready", load_ready, 0);
      load_data = 8'h05;
      step();
      load_valid = 1'b0;
      check("full_ignore_count", count, 4);
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", valid, 1);
         check("drain_data", data, i);
         step();
      end
      ready = 1'b0;
      check("drain_empty_valid", valid, 0);
      check("drain_empty_count", count, 0);

      // Full with simultaneous transfer: the offered word is refused.
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = 8'h21 + WIDTH'(i);
         step();
      end
      check("full2_count", count, 4);
      load_data = 8'h10; ready = 1'b1;
      step();
      load_valid = 1'b0; ready = 1'b0;
      check("full2_xfer_count", count, 3);
      check("full2_load_ready", load_ready, 1);
      ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         check("full2_drain_data", data, 8'h21 + i);
         step();
      end
      ready = 1'b0;
      check("full2_drain_valid", valid, 0);

      // Steady state at count 2 with a load and a transfer every cycle.
      load_valid = 1'b1;
      load_data = 8'h31; step();
      load_data = 8'h32; step();
      check("ss_count_init", count, 2);
      ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         load_data = 8'h33 + WIDTH'(k);
         check("ss_data", data, 8'h31 + k);
         step();
         check("ss_count", count, 2);
      end
      ready = 1'b0;
      load_data = 8'h50;
      step();
      load_valid = 1'b0;
      check("mid_count", count, 3);
      check("mid_valid", valid, 1);
      check("mid_data", data, 8'h39);

      // Reset mid-operation discards everything.
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("midrst_valid", valid, 0);
      check("midrst_count", count, 0);
      check("midrst_load_ready", load_ready, 0);
      step();
      check("midrst_release_load_ready", load_ready, 1);
      check("midrst_release_valid", valid, 0);

      // Random traffic against the reference queue.
      model.delete();
      hold_pending = 1'b0;
      hold_data    = '0;
      for (int c = 0; c < 2000; c++) begin
         ready      = 1'($urandom_range(0, 1));
         load_valid = 1'($urandom_range(0, 1));
         load_data  = WIDTH'($urandom);
         cycle();
      end
      load_valid = 1'b0;
      ready      = 1'b1;
      for (int c = 0; c < DEPTH + 2; c++) cycle();
      check("final_empty_count", count, 0);
      check("final_model_empty", model.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
